softmax_result_collector: RTL and testbench

- Sits directly downstream of the softmax write-data sequencer.
- Captures the OUTPUT_SIZE softmax results that arrive as a (valid_in, sel_in, data_in) beat train and buffers them as one frame.
- Computes the argmax class incrementally while the frame arrives.
- Replays the frame to the result sink over a valid/ready stream and reports sequence errors.

---
 rtl/softmax_result_collector_if.sv | 29 ++
 rtl/softmax_result_collector.sv | 180 ++++++++++++++++++
 tb/tb_softmax_result_collector.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_result_collector_if.sv
// Beat-train input and result-stream output bundle of the softmax result collector.
// master drives beats and out_ready; slave is the collector.
interface softmax_result_collector_if #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned IDX_WIDTH  = 4
);
  logic                  valid_in;
  logic [IDX_WIDTH-1:0]  sel_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  out_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IDX_WIDTH-1:0]  out_idx;
  logic                  class_valid;
  logic [IDX_WIDTH-1:0]  class_idx;
  logic [DATA_WIDTH-1:0] class_val;
  logic                  busy;
  logic                  err_seq;

  modport master (
    output valid_in, sel_in, data_in, out_ready,
    input  out_valid, out_data, out_idx, class_valid, class_idx, class_val, busy, err_seq
  );

  modport slave (
    input  valid_in, sel_in, data_in, out_ready,
    output out_valid, out_data, out_idx, class_valid, class_idx, class_val, busy, err_seq
  );
endinterface

// File: rtl/softmax_result_collector.sv
// Buffers one frame of softmax results, tracks the argmax on the fly and replays
// the frame over a valid/ready stream; flags out-of-sequence beats.
module softmax_result_collector #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned OUTPUT_SIZE = 10,
  parameter int unsigned IDX_WIDTH   = 4
) (
  input logic                     clk,
  input logic                     rst,
  softmax_result_collector_if.slave bus
);

  localparam logic [IDX_WIDTH-1:0] FIRST_SEL = IDX_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0] SECOND_SEL = IDX_WIDTH'(2);
  localparam logic [IDX_WIDTH-1:0] LAST_SEL  = IDX_WIDTH'(OUTPUT_SIZE);
  localparam logic [IDX_WIDTH-1:0] LAST_PTR  = IDX_WIDTH'(OUTPUT_SIZE - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] frame_q [OUTPUT_SIZE];
  logic [IDX_WIDTH-1:0]  exp_q, exp_d;
  logic [DATA_WIDTH-1:0] max_val_q, max_val_d;
  logic [IDX_WIDTH-1:0]  max_idx_q, max_idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_WIDTH-1:0]  out_idx_q, out_idx_d;
  logic                  class_valid_q, class_valid_d;
  logic [IDX_WIDTH-1:0]  class_idx_q, class_idx_d;
  logic [DATA_WIDTH-1:0] class_val_q, class_val_d;
  logic                  err_q, err_d;
  logic                  busy_q;
  logic                  wr_en;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic                  first_beat, beat_ok, hs;
  logic [IDX_WIDTH-1:0]  nxt_ptr;

  assign first_beat = bus.valid_in && (bus.sel_in == FIRST_SEL);
  assign beat_ok    = bus.valid_in && (bus.sel_in == exp_q);
  assign hs         = out_valid_q && bus.out_ready;
  assign nxt_ptr    = out_idx_q + IDX_WIDTH'(1);
  assign wr_idx     = bus.sel_in - IDX_WIDTH'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (first_beat) state_d = COLLECT;
      COLLECT: begin
        if (beat_ok) begin
          if (bus.sel_in == LAST_SEL) state_d = DRAIN;
        end else if (bus.valid_in && !first_beat) begin
          state_d = IDLE;
        end
      end
      DRAIN:   if (hs && (out_idx_q == LAST_PTR)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    exp_d         = exp_q;
    max_val_d     = max_val_q;
    max_idx_d     = max_idx_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_idx_d     = out_idx_q;
    class_valid_d = 1'b0;
    class_idx_d   = class_idx_q;
    class_val_d   = class_val_q;
    err_d         = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      IDLE: begin
        if (first_beat) begin
          wr_en     = 1'b1;
          max_val_d = bus.data_in;
          max_idx_d = '0;
          exp_d     = SECOND_SEL;
        end else if (bus.valid_in) begin
          err_d = 1'b1;
        end
      end
      COLLECT: begin
        if (beat_ok) begin
          wr_en = 1'b1;
          exp_d = exp_q + IDX_WIDTH'(1);
          // Strict compare keeps the lower index on ties
          if (bus.data_in > max_val_q) begin
            max_val_d = bus.data_in;
            max_idx_d = wr_idx;
          end
          if (bus.sel_in == LAST_SEL) begin
            exp_d         = FIRST_SEL;
            class_valid_d = 1'b1;
            class_idx_d   = max_idx_d;
            class_val_d   = max_val_d;
            out_valid_d   = 1'b1;
            out_idx_d     = '0;
            out_data_d    = frame_q[0];
          end
        end else if (bus.valid_in) begin
          err_d = 1'b1;
          if (first_beat) begin
            wr_en     = 1'b1;
            max_val_d = bus.data_in;
            max_idx_d = '0;
            exp_d     = SECOND_SEL;
          end else begin
            exp_d = FIRST_SEL;
          end
        end
      end
      DRAIN: begin
        err_d = bus.valid_in;
        if (hs) begin
          if (out_idx_q == LAST_PTR) begin
            out_valid_d = 1'b0;
            out_idx_d   = '0;
            out_data_d  = '0;
          end else begin
            out_idx_d  = nxt_ptr;
            out_data_d = frame_q[nxt_ptr];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q         <= FIRST_SEL;
      max_val_q     <= '0;
      max_idx_q     <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_idx_q     <= '0;
      class_valid_q <= 1'b0;
      class_idx_q   <= '0;
      class_val_q   <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      exp_q         <= exp_d;
      max_val_q     <= max_val_d;
      max_idx_q     <= max_idx_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_idx_q     <= out_idx_d;
      class_valid_q <= class_valid_d;
      class_idx_q   <= class_idx_d;
      class_val_q   <= class_val_d;
      err_q         <= err_d;
      busy_q        <= (state_d != IDLE);
    end
  end

  // Frame storage needs no reset
  always_ff @(posedge clk) begin
    if (wr_en) frame_q[wr_idx] <= bus.data_in;
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_idx     = out_idx_q;
  assign bus.class_valid = class_valid_q;
  assign bus.class_idx   = class_idx_q;
  assign bus.class_val   = class_val_q;
  assign bus.busy        = busy_q;
  assign bus.err_seq     = err_q;

endmodule

// File: tb/tb_softmax_result_collector.sv
// Scoreboard bench for softmax_result_collector: expected stream and class
// results are queued as frames are sent and compared as the DUT emits them.
module tb_softmax_result_collector;
  localparam int unsigned DW = 24;
  localparam int unsigned N  = 10;
  localparam int unsigned IW = 4;

  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  softmax_result_collector_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

  softmax_result_collector #(.DATA_WIDTH(DW), .OUTPUT_SIZE(N), .IDX_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  item_t         sb_q[$];
  item_t         cls_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            err_cnt  = 0;
  logic [DW-1:0] fdata [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Stream / class monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        if (sb_q.size() == 0) check("out_unexpected", 32'd1, 32'd0);
        else begin
          check("out_data", 32'(bus.out_data), 32'(sb_q[0].d));
          check("out_idx", 32'(bus.out_idx), 32'(sb_q[0].i));
          if (bus.out_ready) void'(sb_q.pop_front());
        end
      end
      if (bus.class_valid) begin
        if (cls_q.size() == 0) check("class_unexpected", 32'd1, 32'd0);
        else begin
          check("class_idx", 32'(bus.class_idx), 32'(cls_q[0].i));
          check("class_val", 32'(bus.class_val), 32'(cls_q[0].d));
          void'(cls_q.pop_front());
        end
      end
      if (bus.err_seq) err_cnt++;
    end
  end

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [IW-1:0] s, input logic [DW-1:0] d);
    bus.valid_in = 1'b1;
    bus.sel_in   = s;
    bus.data_in  = d;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    check({tag, "_out_idx"}, 32'(bus.out_idx), 32'd0);
    check({tag, "_class_valid"}, 32'(bus.class_valid), 32'd0);
    check({tag, "_class_idx"}, 32'(bus.class_idx), 32'd0);
    check({tag, "_class_val"}, 32'(bus.class_val), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_err_seq"}, 32'(bus.err_seq), 32'd0);
  endtask

  task automatic reset_dut(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero(tag);
    rst = 1'b0;
    sb_q.delete();
    cls_q.delete();
  endtask

  // Sends fdata as one frame; expectations are queued before the last beat
  task automatic send_frame(input int gap);
    item_t         it;
    int            mi = 0;
    logic [DW-1:0] mv = fdata[0];
    for (int i = 1; i < N; i++) if (fdata[i] > mv) begin mv = fdata[i]; mi = i; end
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) begin
        for (int k = 0; k < N; k++) begin
          it.d = fdata[k]; it.i = IW'(k); sb_q.push_back(it);
        end
        it.d = mv; it.i = IW'(mi); cls_q.push_back(it);
      end
      beat(IW'(i + 1), fdata[i]);
      if (i < N - 1) repeat (gap) idle();
    end
  endtask

  task automatic wait_drain(input bit bp, input bit inject, output int cycles, output int stalls);
    cycles = 0;
    stalls = 0;
    while (bus.out_valid && cycles < 200) begin
      bus.out_ready = bp ? ((cycles % 4 == 0) || (cycles % 4 == 3)) : 1'b1;
      bus.valid_in  = inject && (cycles == 3);
      bus.sel_in    = IW'(1);
      bus.data_in   = DW'(24'h00ABCD);
      if (!bus.out_ready) stalls++;
      @(posedge clk); #1;
      cycles++;
    end
    bus.out_ready = 1'b1;
    bus.valid_in  = 1'b0;
    check("drain_cycles", 32'(cycles), 32'(N + stalls));
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    check("drain_busy", 32'(bus.busy), 32'd0);
    check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
    check("drain_cls_empty", 32'(cls_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int c, s, ec;
    rst = 1'b1;
    bus.valid_in = 1'b0; bus.sel_in = '0; bus.data_in = '0; bus.out_ready = 1'b1;
    idle();
    reset_dut("reset");
    idle();

    // Nominal ramp
    for (int i = 0; i < N; i++) fdata[i] = DW'(100 * (i + 1));
    ec = err_cnt;
    send_frame(0);
    check("nom_busy", 32'(bus.busy), 32'd1);
    wait_drain(1'b0, 1'b0, c, s);
    check("nom_class_idx_hold", 32'(bus.class_idx), 32'd9);
    check("nom_class_val_hold", 32'(bus.class_val), 32'd1000);
    check("nom_no_err", 32'(err_cnt - ec), 32'd0);

    // Tie with gaps
    fdata = '{24'd5, 24'd9, 24'd9, 24'd3, 24'd8, 24'd7, 24'd6, 24'd4, 24'd2, 24'd1};
    send_frame(2);
    wait_drain(1'b0, 1'b0, c, s);
    check("tie_class_idx", 32'(bus.class_idx), 32'd1);
    check("tie_class_val", 32'(bus.class_val), 32'd9);

    // Backpressure with random data
    for (int i = 0; i < N; i++) fdata[i] = DW'($urandom());
    send_frame(0);
    wait_drain(1'b1, 1'b0, c, s);
    check("bp_stalls", 32'(s), 32'd10);

    // Skipped index
    ec = err_cnt;
    beat(IW'(1), DW'(7)); beat(IW'(2), DW'(8)); beat(IW'(4), DW'(9));
    check("skip_err_pulse", 32'(bus.err_seq), 32'd1);
    check("skip_idle", 32'(bus.busy), 32'd0);
    idle();
    check("skip_err_clear", 32'(bus.err_seq), 32'd0);
    check("skip_err_count", 32'(err_cnt - ec), 32'd1);

    // Restart on sel==1 mid-frame
    ec = err_cnt;
    beat(IW'(1), DW'(50)); beat(IW'(2), DW'(60));
    for (int i = 0; i < N; i++) fdata[i] = DW'($urandom_range(0, 5000));
    send_frame(0);
    wait_drain(1'b0, 1'b0, c, s);
    check("restart_err_count", 32'(err_cnt - ec), 32'd1);

    // Illegal sel 0 in IDLE
    ec = err_cnt;
    beat(IW'(0), DW'(3));
    check("sel0_err_pulse", 32'(bus.err_seq), 32'd1);
    check("sel0_idle", 32'(bus.busy), 32'd0);
    idle();
    check("sel0_err_count", 32'(err_cnt - ec), 32'd1);

    // Beat injected during drain
    for (int i = 0; i < N; i++) fdata[i] = DW'($urandom());
    ec = err_cnt;
    send_frame(0);
    wait_drain(1'b0, 1'b1, c, s);
    check("inject_err_count", 32'(err_cnt - ec), 32'd1);

    // Reset mid-collect, then a fresh frame
    for (int i = 1; i <= 5; i++) beat(IW'(i), DW'(i * 11));
    reset_dut("rst_collect");
    for (int i = 0; i < N; i++) fdata[i] = DW'(N - i);
    send_frame(0);
    wait_drain(1'b0, 1'b0, c, s);
    check("post_rst_class_idx", 32'(bus.class_idx), 32'd0);
    check("post_rst_class_val", 32'(bus.class_val), 32'(N));

    // Reset mid-drain, then a fresh frame
    for (int i = 0; i < N; i++) fdata[i] = DW'($urandom());
    send_frame(0);
    repeat (4) idle();
    reset_dut("rst_drain");
    idle();
    for (int i = 0; i < N; i++) fdata[i] = DW'($urandom());
    send_frame(1);
    wait_drain(1'b1, 1'b0, c, s);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
